ui_debounce: RTL and testbench
==============================

# ui_debounce

Multi-lane input conditioner that sits directly upstream of the nibble-inverter tile, between the raw `ui_in` switch pins and the logic that consumes them. Each lane is synchronised through two flip-flops, then accepted only after it has held a new level for a programmable number of consecutive clock cycles. The block presents clean levels, and optionally one-cycle edge pulses, so that switch bounce never reaches downstream logic.

## Interface
- `WIDTH`, default 8: number of independent lanes.
- `CNT_W`, default 16: width of each lane's stability counter.
- `DEBOUNCE_CYCLES`, default 1000: consecutive synchronised cycles a new level must hold before it is accepted. Legal range is 1 to 2^CNT_W−1; an out-of-range value is an elaboration error.

- `clk`  input  1  the single clock. All state updates on the rising edge.
- `rst`  input  1  synchronous reset, active-high.
- `din`  input  WIDTH  raw asynchronous lane inputs.
- `dout`  output  WIDTH  debounced level per lane; registered.
- `rise`  output  WIDTH  one-cycle pulse when `dout[i]` goes 0→1; registered.
- `fall`  output  WIDTH  one-cycle pulse when `dout[i]` goes 1→0; registered.
- `busy`  output  1  high while any lane counter is nonzero. It is the OR of the counter registers, with no extra register stage.

## Operation
- Reset: a synchronous `rst`=1 at a clock edge clears the following to 0:
  - both synchroniser stages (`s1`, `s2`);
  - every counter;
  - `dout`, `rise` and `fall`.
  - Consequently `busy` is 0 after reset.
- Reset takes priority over every other event on the same edge.
- Synchroniser: on each edge, `s1` ← `din` and `s2` ← `s1`.
- Per-lane counter `cnt[i]`, evaluated on each edge when not in reset:
  - if `s2[i]` equals `dout[i]`: `cnt[i]` ← 0;
  - else if `cnt[i]` equals `DEBOUNCE_CYCLES`−1: `dout[i]` ← `s2[i]`, `cnt[i]` ← 0, and the matching edge pulse is set for one cycle;
  - else: `cnt[i]` ← `cnt[i]`+1.
- Glitch rejection: if `s2[i]` returns to `dout[i]` before acceptance, `cnt[i]` clears to 0 and nothing is output. A later change restarts the count from 0.
- The counter never exceeds `DEBOUNCE_CYCLES`−1, so no wrap-around or saturation logic is required.
- Lanes are fully independent. Any mix of lanes may rise or fall on the same edge, and each sets only its own bits.
- Reset during a count discards the partial count. If `din[i]` is still 1 after reset, `dout[i]` stays 0 until that level is re-debounced in full.

## Timing
- Latency is counted with the first edge that samples a new `din` level into `s1` as edge 1.
  - `s2` holds the new level after edge 2.
  - `dout` changes on edge 2+`DEBOUNCE_CYCLES`, provided `din` is stable throughout.
  - With `DEBOUNCE_CYCLES`=1, `dout` changes on edge 3.
- `rise[i]` and `fall[i]` assert on the same edge that `dout[i]` changes. They deassert on the next edge.
- `rise[i]` and `fall[i]` are never both high.
- `busy` rises after the first edge on which `cnt` increments. It falls after the edge that accepts the new level or clears the counter.
- Minimum time between two accepted changes on one lane is `DEBOUNCE_CYCLES` cycles.
- There are no combinational paths from `din` to any output.

## Configuration
- `UI_DEBOUNCE_EDGE_EN` defined:
  - the `rise` and `fall` registers and their logic are compiled in;
  - the pulses behave as described above.
- `UI_DEBOUNCE_EDGE_EN` undefined:
  - no edge registers are built;
  - `rise` and `fall` are tied to constant 0;
  - `dout` and `busy` behaviour is unchanged.

## Test plan
- **Reset:** `din`=8'hFF held, `rst`=1 for 2 edges → `dout`=8'h00, `rise`=`fall`=0 and `busy`=0. After release, `dout` becomes 8'hFF on edge 2+`DEBOUNCE_CYCLES`.
- **Clean step:** `DEBOUNCE_CYCLES`=4, `din[0]` 0→1 and held → `dout[0]`=1 exactly on edge 6, `rise[0]`=1 for that one cycle only, and `busy` high for edges 3 to 5.
- **Glitch:** `DEBOUNCE_CYCLES`=4, `din[2]` high for 3 cycles then low → `dout[2]` stays 0, no `rise`, and `busy` returns to 0 with `cnt[2]`=0. A following 5-cycle high pulse is accepted.
- **Simultaneous lanes:** start with `dout`=8'h0F, then `din`=8'hF0 → on the same edge `dout`=8'hF0, `rise`=8'hF0 and `fall`=8'h0F.
- **Reset mid-count:** `DEBOUNCE_CYCLES`=8, `din[5]`=1, `rst` pulsed on edge 6 → `dout[5]` stays 0 until a full 2+8 edges after reset release.
- **Macro off:** build without `UI_DEBOUNCE_EDGE_EN`, repeat the clean step → `dout` timing is identical and `rise`/`fall` stay 8'h00.

Source files
------------

// File: rtl/ui_debounce.sv
// ui_debounce: multi-lane switch conditioner.
// Each lane passes through a two-flop synchroniser and is accepted only after
// holding a new level for DEBOUNCE_CYCLES consecutive clocks.
// Optional feature macro: UI_DEBOUNCE_EDGE_EN builds the one-cycle rise/fall
// pulse registers; without it rise and fall are constant zero.
module ui_debounce #(
   parameter int WIDTH           = 8,
   parameter int CNT_W           = 16,
   parameter int DEBOUNCE_CYCLES = 1000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall,
   output logic             busy
);

   // Terminal count: a lane is accepted on the edge where its counter sits here.
   localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   // Reject a debounce length the counter cannot represent.
   if ((DEBOUNCE_CYCLES < 1) || (DEBOUNCE_CYCLES > ((2 ** CNT_W) - 1))) begin : g_bad_cycles
      $error("ui_debounce: DEBOUNCE_CYCLES out of range 1..2^CNT_W-1");
   end

   logic [WIDTH-1:0] r_s1;
   logic [WIDTH-1:0] r_s2;
   logic [CNT_W-1:0] r_cnt [WIDTH];
   logic [WIDTH-1:0] r_dout;
   logic [WIDTH-1:0] w_accept;
   logic             w_busy;

   // Two-stage synchroniser bringing the raw pins into the clock domain.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1 <= '0;
         r_s2 <= '0;
      end else begin
         r_s1 <= din;
         r_s2 <= r_s1;
      end
   end

   // A lane is accepted when it differs from the output and has counted out.
   always_comb begin
      w_accept = '0;
      for (int i = 0; i < WIDTH; i++) begin
         w_accept[i] = (r_s2[i] != r_dout[i]) && (r_cnt[i] == LP_LAST);
      end
   end

   // Per-lane stability counter and debounced level; any return to the
   // current output level discards the partial count.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_dout <= '0;
         for (int i = 0; i < WIDTH; i++) begin
            r_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (r_s2[i] == r_dout[i]) begin
               r_cnt[i] <= '0;
            end else if (w_accept[i]) begin
               r_dout[i] <= r_s2[i];
               r_cnt[i]  <= '0;
            end else begin
               r_cnt[i] <= r_cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   // Busy is the plain OR of all counters so it tracks them with no lag.
   always_comb begin
      w_busy = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         w_busy = w_busy | (r_cnt[i] != '0);
      end
   end

   assign dout = r_dout;
   assign busy = w_busy;

`ifdef UI_DEBOUNCE_EDGE_EN
   logic [WIDTH-1:0] r_rise;
   logic [WIDTH-1:0] r_fall;

   // Edge pulses fire on the accepting edge and clear on the next one.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rise <= '0;
         r_fall <= '0;
      end else begin
         r_rise <= w_accept & r_s2;
         r_fall <= w_accept & ~r_s2;
      end
   end

   assign rise = r_rise;
   assign fall = r_fall;
`else
   assign rise = '0;
   assign fall = '0;
`endif

endmodule

// File: tb/tb_ui_debounce.sv
// tb_ui_debounce: directed self-checking bench for ui_debounce.
// Main instance uses DEBOUNCE_CYCLES=4; a second instance with
// DEBOUNCE_CYCLES=1 shares the inputs to cover the shortest setting.
// Edge expectations follow UI_DEBOUNCE_EDGE_EN as the design is built.
module tb_ui_debounce;

   logic       clk;
   logic       rst;
   logic [7:0] din;
   logic [7:0] dout,  rise,  fall;
   logic       busy;
   logic [7:0] dout1, rise1, fall1;
   logic       busy1;

   int checks;
   int errors;

`ifdef UI_DEBOUNCE_EDGE_EN
   localparam logic [7:0] EDGE_MASK = 8'hFF;
`else
   localparam logic [7:0] EDGE_MASK = 8'h00;
`endif

   typedef struct {
      logic [7:0] din;
      logic       rst;
      logic [7:0] dout;
      logic [7:0] rise;
      logic [7:0] fall;
      logic       busy;
      logic [7:0] dout1;
      logic [7:0] rise1;
      logic [7:0] fall1;
   } vec_t;

   vec_t vecs[$];

   ui_debounce #(.WIDTH(8), .CNT_W(16), .DEBOUNCE_CYCLES(4)) dut (
      .clk(clk), .rst(rst), .din(din),
      .dout(dout), .rise(rise), .fall(fall), .busy(busy)
   );

   ui_debounce #(.WIDTH(8), .CNT_W(16), .DEBOUNCE_CYCLES(1)) dut1 (
      .clk(clk), .rst(rst), .din(din),
      .dout(dout1), .rise(rise1), .fall(fall1), .busy(busy1)
   );

   // Free-running clock, 10 time units per period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive inputs on the falling edge, then step to just after the next rising edge.
   task automatic applyStimulus(input logic [7:0] d, input logic r);
      @(negedge clk);
      din = d;
      rst = r;
      @(posedge clk);
      #1;
   endtask

   task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic checkOutput(input string name, input logic [7:0] eDout,
                              input logic [7:0] eRise, input logic [7:0] eFall,
                              input logic eBusy);
      check8({name, " dout"}, dout, eDout);
      check8({name, " rise"}, rise, eRise & EDGE_MASK);
      check8({name, " fall"}, fall, eFall & EDGE_MASK);
      check8({name, " busy"}, {7'd0, busy}, {7'd0, eBusy});
   endtask

   // Hand-computed step response for a clean level change: for DEBOUNCE_CYCLES=4
   // the output moves on edge 6 and busy is high after edges 3..5; for
   // DEBOUNCE_CYCLES=1 the output moves on edge 3.
   task automatic addSegment(input logic [7:0] oldV, input logic [7:0] newV);
      vec_t v;
      for (int k = 1; k <= 7; k++) begin
         v.din   = newV;
         v.rst   = 1'b0;
         v.dout  = (k >= 6) ? newV : oldV;
         v.rise  = (k == 6) ? (newV & ~oldV) : 8'h00;
         v.fall  = (k == 6) ? (oldV & ~newV) : 8'h00;
         v.busy  = (k >= 3) && (k <= 5) && (newV != oldV);
         v.dout1 = (k >= 3) ? newV : oldV;
         v.rise1 = (k == 3) ? (newV & ~oldV) : 8'h00;
         v.fall1 = (k == 3) ? (oldV & ~newV) : 8'h00;
         vecs.push_back(v);
      end
   endtask

   initial begin
      vec_t v;
      checks = 0;
      errors = 0;
      din    = 8'h00;
      rst    = 1'b1;

      // Reset with all pins high, then four clean steps including the
      // simultaneous 0F -> F0 swap and a single-lane rise on lane 0.
      v = '{din: 8'hFF, rst: 1'b1, dout: 8'h00, rise: 8'h00, fall: 8'h00,
            busy: 1'b0, dout1: 8'h00, rise1: 8'h00, fall1: 8'h00};
      vecs.push_back(v);
      vecs.push_back(v);
      addSegment(8'h00, 8'hFF);
      addSegment(8'hFF, 8'h0F);
      addSegment(8'h0F, 8'hF0);
      addSegment(8'hF0, 8'hF1);

      for (int n = 0; n < vecs.size(); n++) begin
         applyStimulus(vecs[n].din, vecs[n].rst);
         checkOutput($sformatf("vec%0d", n), vecs[n].dout, vecs[n].rise,
                     vecs[n].fall, vecs[n].busy);
         check8($sformatf("vec%0d dout1", n), dout1, vecs[n].dout1);
         check8($sformatf("vec%0d rise1", n), rise1, vecs[n].rise1 & EDGE_MASK);
         check8($sformatf("vec%0d fall1", n), fall1, vecs[n].fall1 & EDGE_MASK);
         check8($sformatf("vec%0d busy1", n), {7'd0, busy1}, 8'h00);
      end

      // Glitch on lane 2: high for 3 cycles never reaches acceptance.
      for (int k = 1; k <= 9; k++) begin
         applyStimulus((k <= 3) ? 8'hF5 : 8'hF1, 1'b0);
         check8($sformatf("glitch e%0d dout", k), dout, 8'hF1);
         check8($sformatf("glitch e%0d rise", k), rise, 8'h00);
         check8($sformatf("glitch e%0d busy", k), {7'd0, busy},
                {7'd0, (k >= 3) && (k <= 5)});
      end

      // A 5-cycle high pulse on lane 2 is accepted on edge 6.
      for (int k = 1; k <= 6; k++) begin
         applyStimulus((k <= 5) ? 8'hF5 : 8'hF1, 1'b0);
         if (k < 6) check8($sformatf("pulse e%0d dout", k), dout, 8'hF1);
      end
      checkOutput("pulse accept", 8'hF5, 8'h04, 8'h00, 1'b0);

      // The trailing low level is itself debounced back to F1.
      for (int k = 1; k <= 10; k++) applyStimulus(8'hF1, 1'b0);
      checkOutput("pulse settle", 8'hF1, 8'h00, 8'h00, 1'b0);

      // Clear all lanes before the reset mid-count sequence.
      for (int k = 1; k <= 8; k++) applyStimulus(8'h00, 1'b0);
      checkOutput("clear", 8'h00, 8'h00, 8'h00, 1'b0);

      // Lane 5 counting, reset on edge 5 discards the partial count.
      for (int k = 1; k <= 4; k++) applyStimulus(8'h20, 1'b0);
      check8("midcount busy", {7'd0, busy}, 8'h01);
      applyStimulus(8'h20, 1'b1);
      checkOutput("midcount reset", 8'h00, 8'h00, 8'h00, 1'b0);
      for (int k = 1; k <= 6; k++) begin
         applyStimulus(8'h20, 1'b0);
         if (k < 6) check8($sformatf("postreset e%0d dout", k), dout, 8'h00);
      end
      checkOutput("postreset accept", 8'h20, 8'h20, 8'h00, 1'b0);
      applyStimulus(8'h20, 1'b0);
      checkOutput("postreset hold", 8'h20, 8'h00, 8'h00, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
